// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing and ALU control.
// Optional PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [3:0]  op_sel,
    output logic [2:0]  state,
    output logic        illegal
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t      cur;
    state_t      nxt;
    logic [31:0] instr;

    logic [6:0] opc;
    logic [2:0] f3;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br;
    logic is_ld, is_st, is_opi, is_op, is_legal;

    assign opc      = instr[6:0];
    assign f3       = instr[14:12];
    assign is_lui   = (opc == 7'b0110111);
    assign is_auipc = (opc == 7'b0010111);
    assign is_jal   = (opc == 7'b1101111);
    assign is_jalr  = (opc == 7'b1100111);
    assign is_br    = (opc == 7'b1100011);
    assign is_ld    = (opc == 7'b0000011);
    assign is_st    = (opc == 7'b0100011);
    assign is_opi   = (opc == 7'b0010011);
    assign is_op    = (opc == 7'b0110011);
    assign is_legal = is_lui | is_auipc | is_jal | is_jalr | is_br
                    | is_ld | is_st | is_opi | is_op;

    // Only opcode, funct3 and bit 30 steer control; the rest feeds the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= FETCH;
            instr   <= '0;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (ir_we)
                instr <= imem_rdata;
            if (nxt == TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt       = cur;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        rf_we     = 1'b0;
        pc_sel    = 2'b00;
        wb_sel    = 2'b00;
        op_sel    = 4'b0000;
        alu_a_sel = is_auipc | is_jal | is_br;
        alu_b_sel = ~is_op;

        unique case (1'b1)
            is_op:  op_sel = {instr[30], f3};
            is_opi: op_sel = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
            is_lui: op_sel = 4'b1111;
            default: op_sel = 4'b0000;
        endcase

        case (cur)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we = 1'b1;
                    nxt   = DECODE;
                end
            end
            DECODE: nxt = is_legal ? EXEC : TRAP;
            EXEC: begin
                if (is_ld || is_st) begin
                    nxt = MEM;
                end else if (is_br) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                    nxt    = FETCH;
                end else begin
                    nxt = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ack) begin
                    if (is_ld) begin
                        nxt = WB;
                    end else begin
                        pc_we = 1'b1;
                        nxt   = FETCH;
                    end
                end
            end
            WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                wb_sel = is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : 2'b00;
                pc_sel = is_jal ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
                nxt    = FETCH;
            end
            TRAP: begin
                alu_a_sel = 1'b0;
                alu_b_sel = 1'b0;
                nxt       = TRAP;
            end
            default: nxt = FETCH;
        endcase

        // Reset wins over any in-flight handshake.
        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            dmem_we  = 1'b0;
            pc_we    = 1'b0;
            ir_we    = 1'b0;
            rf_we    = 1'b0;
            pc_sel   = 2'b00;
            wb_sel   = 2'b00;
            op_sel   = 4'b0000;
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions, per-retire checks.
// Memory responders add programmable ack latency; trap and reset cases are directed.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_rdata;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        branch_taken;
    logic        imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we;
    logic [1:0]  pc_sel, wb_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [3:0]  op_sel;
    logic [2:0]  state;
    logic        illegal;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .branch_taken(branch_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we),
        .pc_sel(pc_sel), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .op_sel(op_sel), .state(state), .illegal(illegal)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] pcs;
        logic [1:0] wbs;
        logic [3:0] ops;
        logic       asel;
        logic       bsel;
        logic [7:0] lat;
        logic [7:0] dreq;
        logic       dwe;
        logic [3:0] rfw;
    } exp_t;

    exp_t  exq[$];
    string nmq[$];

    int errors = 0;
    int checks = 0;
    int retired = 0;
    int issued = 0;
    int fetched = 0;
    int imem_dly = 0;
    int dmem_dly = 0;
    int icnt = 0;
    int dcnt = 0;
    logic [31:0] cur_instr = 32'h0;
    logic        cur_taken = 1'b0;

    assign imem_rdata   = cur_instr;
    assign branch_taken = cur_taken;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic exp_t mk(int st, int pcs, int wbs, int ops, int asel,
                                int bsel, int lat, int dreq, int dwe, int rfw);
        exp_t e;
        e.st = 3'(st); e.pcs = 2'(pcs); e.wbs = 2'(wbs); e.ops = 4'(ops);
        e.asel = 1'(asel); e.bsel = 1'(bsel); e.lat = 8'(lat);
        e.dreq = 8'(dreq); e.dwe = 1'(dwe); e.rfw = 4'(rfw);
        return e;
    endfunction

    // Memory responders: ack after a programmable number of wait cycles.
    always @(negedge clk) begin
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!reset && imem_req && issued != fetched) begin
            if (icnt >= imem_dly) begin
                imem_ack = 1'b1;
                fetched++;
                icnt = 0;
            end else begin
                icnt++;
            end
        end else begin
            icnt = 0;
        end
        if (!reset && dmem_req) begin
            if (dcnt >= dmem_dly) begin
                dmem_ack = 1'b1;
                dcnt = 0;
            end else begin
                dcnt++;
            end
        end else begin
            dcnt = 0;
        end
    end

    // Monitor: track each instruction from ir_we, compare on every pc_we.
    int m_lat = 0, m_dreq = 0, m_dwe = 0, m_rfw = 0;
    always begin
        @(negedge clk);
        #2;
        if (reset) begin
            m_lat = 0; m_dreq = 0; m_dwe = 0; m_rfw = 0;
        end else begin
            if (ir_we) begin
                m_lat = 0; m_dreq = 0; m_dwe = 0; m_rfw = 0;
            end else begin
                m_lat++;
            end
            if (dmem_req) m_dreq++;
            if (dmem_we)  m_dwe = 1;
            if (rf_we)    m_rfw++;
            if (pc_we) begin
                exp_t  a;
                exp_t  e;
                string nm;
                a = mk(state, pc_sel, wb_sel, op_sel, alu_a_sel, alu_b_sel,
                       m_lat, m_dreq, m_dwe, m_rfw);
                checks++;
                if (exq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_retire: got st=%0d expected none", state);
                end else begin
                    e  = exq.pop_front();
                    nm = nmq.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL %s: got st=%0d pcs=%0d wbs=%0d ops=%b a=%0d b=%0d lat=%0d dreq=%0d dwe=%0d rfw=%0d expected st=%0d pcs=%0d wbs=%0d ops=%b a=%0d b=%0d lat=%0d dreq=%0d dwe=%0d rfw=%0d",
                            nm, a.st, a.pcs, a.wbs, a.ops, a.asel, a.bsel, a.lat, a.dreq, a.dwe, a.rfw,
                            e.st, e.pcs, e.wbs, e.ops, e.asel, e.bsel, e.lat, e.dreq, e.dwe, e.rfw);
                    end
                end
                retired++;
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] ins, input bit tk,
                         input int idly, input int ddly, input exp_t e);
        int start;
        exq.push_back(e);
        nmq.push_back(nm);
        cur_instr = ins;
        cur_taken = tk;
        imem_dly  = idly;
        dmem_dly  = ddly;
        start     = retired;
        issued++;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (retired != start) break;
        end
        if (retired == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no retire expected retire within 80 cycles", nm);
            exq.delete();
            nmq.delete();
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_state"}, 64'(state), 64'd0);
        chk({nm, "_illegal"}, 64'(illegal), 64'd0);
        chk({nm, "_req_en"}, 64'({imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we}), 64'd0);
        chk({nm, "_sels"}, 64'({pc_sel, wb_sel, op_sel}), 64'd0);
`ifdef PERF_CNT_EN
        chk({nm, "_cnts"}, {cycle_cnt, instret_cnt}, 64'd0);
`endif
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("release_imem_req", 64'({imem_req, state}), 64'({1'b1, 3'd0}));

        issue("add",   32'h002081B3, 0, 0, 0, mk(4, 0, 0, 4'b0000, 0, 0, 3, 0, 0, 1));
        issue("sub",   32'h402081B3, 0, 2, 0, mk(4, 0, 0, 4'b1000, 0, 0, 3, 0, 0, 1));
        issue("srai",  32'h4020D093, 0, 0, 0, mk(4, 0, 0, 4'b1101, 0, 1, 3, 0, 0, 1));
        issue("slli",  32'h40109093, 0, 1, 0, mk(4, 0, 0, 4'b0001, 0, 1, 3, 0, 0, 1));
        issue("ori",   32'h0010E093, 0, 0, 0, mk(4, 0, 0, 4'b0110, 0, 1, 3, 0, 0, 1));
        issue("lui",   32'h123450B7, 0, 0, 0, mk(4, 0, 0, 4'b1111, 0, 1, 3, 0, 0, 1));
        issue("auipc", 32'h00001097, 0, 0, 0, mk(4, 0, 0, 4'b0000, 1, 1, 3, 0, 0, 1));
        issue("lw_d3", 32'h00012083, 0, 0, 3, mk(4, 0, 1, 4'b0000, 0, 1, 7, 4, 0, 1));
        issue("lw_d0", 32'h00012083, 0, 0, 0, mk(4, 0, 1, 4'b0000, 0, 1, 4, 1, 0, 1));
        issue("sw_d1", 32'h00112223, 0, 0, 1, mk(3, 0, 0, 4'b0000, 0, 1, 4, 2, 1, 0));
        issue("beq_t", 32'h00208463, 1, 0, 0, mk(2, 1, 0, 4'b0000, 1, 1, 2, 0, 0, 0));
        issue("beq_n", 32'h00208463, 0, 0, 0, mk(2, 0, 0, 4'b0000, 1, 1, 2, 0, 0, 0));
        issue("jal",   32'h010000EF, 0, 0, 0, mk(4, 1, 2, 4'b0000, 1, 1, 3, 0, 0, 1));
        issue("jalr",  32'h000100E7, 0, 0, 0, mk(4, 2, 2, 4'b0000, 0, 1, 3, 0, 0, 1));

        chk("no_illegal", 64'(illegal), 64'd0);
`ifdef PERF_CNT_EN
        chk("instret", 64'(instret_cnt), 64'd14);
`endif

        // Illegal opcode: trap and stay there until reset.
        cur_instr = 32'hFFFFFFFF;
        issued++;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (state == 3'd5) break;
        end
        chk("trap_entry", 64'(state), 64'd5);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (state == 3'd5 && illegal &&
                !{imem_req, dmem_req, dmem_we, pc_we, ir_we, rf_we})
                n++;
        end
        chk("trap_hold", 64'(n), 64'd20);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("trap_reset");
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a stalled load.
        cur_instr = 32'h00012083;
        dmem_dly  = 50;
        issued++;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (dmem_req) break;
        end
        chk("mem_reached", 64'({state, dmem_req}), 64'({3'd3, 1'b1}));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mem_reset_drop", 64'({dmem_req, imem_req, state}), 64'd0);
        @(negedge clk);
        #1;
        check_reset_outputs("mem_reset");
        reset = 1'b0;
        #1;
        chk("mem_release_req", 64'({imem_req, state}), 64'({1'b1, 3'd0}));
`ifdef PERF_CNT_EN
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_after_release", {cycle_cnt, instret_cnt}, {32'd5, 32'd0});
`endif
        chk("scoreboard_empty", 64'(exq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
